f5_checker: RTL and testbench
=============================

# f5_checker

Self-test sequencer wrapped around the two-input OR gate stage (NAND-built and expression-built variants). Upstream, it drives the gate's `x`/`y` inputs through all four truth-table vectors. Downstream, it samples both gate outputs `a`/`b` after a settle window and compares each against the expected `x|y`. It counts mismatches and reports a pass/fail verdict, replacing the hand-read `$monitor` check with a synthesizable, clocked checker.

## Interface
- `SETTLE`, 1: cycles `x`/`y` are held before sampling; legal range 1..15.
- `CNT_W`, 4: width of the mismatch counter; minimum 2.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  begin a run; sampled only in IDLE.
- `a`  in  1  output of gate variant A under test.
- `b`  in  1  output of gate variant B under test.
- `x`  out  1  gate input 1; registered.
- `y`  out  1  gate input 2; registered.
- `vec_idx`  out  2  index of the vector currently applied; `x=vec_idx[1]`, `y=vec_idx[0]`.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse at the end of a run.
- `pass`  out  1  verdict of the last completed run (1 = zero mismatches).
- `err_cnt`  out  CNT_W  mismatch count of the current or last run.

## Operation
- Reset values: state IDLE, `x=0`, `y=0`, `vec_idx=0`, `busy=0`, `done=0`, `pass=0`, `err_cnt=0`. `rst_n` low mid-run aborts immediately; no partial verdict is kept.
- States: IDLE, WAIT, SAMPLE, DONE.
- IDLE
  - With `start=1`: `vec_idx<=0`, `x<=0`, `y<=0`, `err_cnt<=0`, settle counter `<=SETTLE-1`, go to WAIT.
  - Otherwise stay; all outputs hold.
- WAIT
  - Settle counter 0: go to SAMPLE.
  - Otherwise decrement the counter.
  - WAIT lasts exactly SETTLE cycles.
- SAMPLE (one cycle)
  - Expected value is `e = x|y`.
  - `err_cnt` increases by `(a!=e) + (b!=e)`, saturating at all-ones.
  - If `vec_idx==3`: go to DONE.
  - Otherwise: increment `vec_idx`, load `x`/`y` from the new index, reload the settle counter, go to WAIT.
- DONE (one cycle)
  - `done=1`; `pass<=` (final `err_cnt`==0); go to IDLE.
  - `err_cnt`, `pass`, `vec_idx`, `x` and `y` then hold until the next `start`.
- `start` is ignored while `busy=1`. `start` held high continuously re-launches a run on each return to IDLE.
- Vector order is fixed: 00, 01, 10, 11.
- Maximum raw mismatch count is 8. Any `CNT_W<4` saturates.

## Timing
- `start` sampled at edge T0. The first vector is visible after T0. SAMPLE occurs at cycle T0+SETTLE+1.
- Each vector occupies SETTLE+1 cycles.
- `done` is high during cycle T0+4·(SETTLE+1)+1. For SETTLE=1 that is 9 cycles after T0.
- `pass` and final `err_cnt` are valid in the same cycle as `done`, and remain valid afterwards.
- `a`/`b` must settle combinationally within SETTLE cycles of an `x`/`y` change. The gate under test is combinational, so SETTLE=1 is sufficient.

## Configuration
- `F5_STOP_ON_FAIL_EN`
  - Defined: a SAMPLE with any mismatch goes directly to DONE. `vec_idx`, `x` and `y` hold the first failing vector, and `err_cnt` holds that vector's mismatches only (1 or 2).
  - Undefined: all four vectors always run and `err_cnt` is the total.

## Test plan
- Both inputs tied to the correct OR of `x`/`y`, SETTLE=1, pulse `start` -> `done` 9 cycles after T0, `pass=1`, `err_cnt=0`; `x`/`y` walk 00,01,10,11 with `busy=1` throughout.
- `a` stuck at 0, `b` correct -> `err_cnt=3`, `pass=0`. With `F5_STOP_ON_FAIL_EN` defined: `done` at cycle T0+5, `vec_idx=1`, `err_cnt=1`.
- `a` and `b` both driven as NOR (inverted) -> `err_cnt=8` with CNT_W=4; rerun with CNT_W=2 -> `err_cnt=3` (saturated), `pass=0`.
- `start` pulsed again at cycle T0+3 of a run -> ignored; `done` still at T0+9 and exactly one pulse.
- `rst_n` low at cycle T0+5 -> `x`,`y`,`err_cnt`,`busy`,`pass` all 0 immediately (before the next edge); a new `start` after release completes normally.
- SETTLE=3, correct gate -> `done` at T0+17; each `x`/`y` value is held 4 cycles.

Source files
------------

// File: rtl/f5_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : f5_checker
// Purpose  : Clocked self-test sequencer for a two-input OR gate stage built
//            two ways (variants A and B). Walks the gate inputs through the
//            four truth-table vectors 00,01,10,11, waits a settle window, then
//            compares both gate outputs against x|y and accumulates a
//            saturating mismatch count and a pass/fail verdict.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   SETTLE  cycles x/y are held before sampling (1..15)
//   CNT_W   mismatch counter width (>= 2)
// Ports
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   begin a run (honoured only while idle)
//   a, b     in   outputs of gate variants A and B
//   x, y     out  gate inputs (x = vec_idx[1], y = vec_idx[0])
//   vec_idx  out  index of the vector currently applied
//   busy     out  high whenever a run is in progress (not idle)
//   done     out  one-cycle pulse at the end of a run
//   pass     out  verdict of the last completed run (1 = no mismatches)
//   err_cnt  out  mismatch count of the current or last run
// Configuration macro
//   F5_STOP_ON_FAIL_EN  when defined, the first failing vector ends the run
//                       and its vector index / mismatches are left visible.
// ============================================================================
module f5_checker #(
  parameter int SETTLE = 1,
  parameter int CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             a,
  input  logic             b,
  output logic             x,
  output logic             y,
  output logic [1:0]       vec_idx,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0]       SETTLE_LD = 4'(SETTLE - 1);
  localparam logic [CNT_W:0]   ERR_MAX   = {1'b0, {CNT_W{1'b1}}};

  state_t           state;
  state_t           state_nx;
  logic [3:0]       settle_cnt;

  logic             expect_val;
  logic [1:0]       miss;
  logic [CNT_W:0]   err_sum;
  logic [CNT_W-1:0] err_nx;

  // Gate inputs come straight from the registered vector index, so they are
  // glitch-free and change only on the clock edge that leaves SAMPLE.
  assign x    = vec_idx[1];
  assign y    = vec_idx[0];
  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // Mismatch accumulation with saturation at all-ones.
  always_comb begin
    expect_val = x | y;
    miss       = {1'b0, (a != expect_val)} + {1'b0, (b != expect_val)};
    err_sum    = {1'b0, err_cnt} + {{(CNT_W-1){1'b0}}, miss};
    if (err_sum > ERR_MAX) begin
      err_nx = {CNT_W{1'b1}};
    end else begin
      err_nx = err_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (settle_cnt == 4'd0) begin
          state_nx = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (vec_idx == 2'd3) begin
          state_nx = S_DONE;
`ifdef F5_STOP_ON_FAIL_EN
        end else if (miss != 2'd0) begin
          state_nx = S_DONE;
`endif
        end else begin
          state_nx = S_WAIT;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_idx    <= 2'd0;
      settle_cnt <= 4'd0;
      err_cnt    <= '0;
      pass       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            vec_idx    <= 2'd0;
            err_cnt    <= '0;
            settle_cnt <= SETTLE_LD;
          end
        end
        S_WAIT: begin
          if (settle_cnt != 4'd0) begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        S_SAMPLE: begin
          err_cnt <= err_nx;
          if (state_nx == S_WAIT) begin
            vec_idx    <= vec_idx + 2'd1;
            settle_cnt <= SETTLE_LD;
          end
          // The verdict is latched on entry to DONE (from the final count) so
          // that it is already valid in the same cycle as the done pulse.
          if (state_nx == S_DONE) begin
            pass <= (err_nx == '0);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_f5_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_f5_checker
// Purpose  : Self-checking bench for f5_checker. Three instances cover
//            SETTLE=1/CNT_W=4, SETTLE=1/CNT_W=2 and SETTLE=3/CNT_W=4. Each
//            gate under test is modelled as correct OR, variant A stuck at 0,
//            or both variants inverted (NOR). Expected run results are queued
//            when a run is launched and compared when done is observed.
// Revision : 1.0  initial release
// ============================================================================
module tb_f5_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start_v [3];
  int         mode_v  [3];
  logic       x_v     [3];
  logic       y_v     [3];
  logic       a_v     [3];
  logic       b_v     [3];
  logic       busy_v  [3];
  logic       done_v  [3];
  logic       pass_v  [3];
  logic [1:0] vec_v   [3];
  logic [3:0] err0;
  logic [1:0] err1;
  logic [3:0] err2;

  int settle_of [3] = '{1, 1, 3};

  int checks   = 0;
  int failures = 0;

  // mode 0: correct OR; 1: variant A stuck at 0; 2: both inverted (NOR)
  function automatic logic gate_a(int m, logic gx, logic gy);
    if (m == 1) return 1'b0;
    if (m == 2) return ~(gx | gy);
    return gx | gy;
  endfunction

  function automatic logic gate_b(int m, logic gx, logic gy);
    if (m == 2) return ~(gx | gy);
    return gx | gy;
  endfunction

  assign a_v[0] = gate_a(mode_v[0], x_v[0], y_v[0]);
  assign b_v[0] = gate_b(mode_v[0], x_v[0], y_v[0]);
  assign a_v[1] = gate_a(mode_v[1], x_v[1], y_v[1]);
  assign b_v[1] = gate_b(mode_v[1], x_v[1], y_v[1]);
  assign a_v[2] = gate_a(mode_v[2], x_v[2], y_v[2]);
  assign b_v[2] = gate_b(mode_v[2], x_v[2], y_v[2]);

  f5_checker #(.SETTLE(1), .CNT_W(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]),
    .x(x_v[0]), .y(y_v[0]), .vec_idx(vec_v[0]), .busy(busy_v[0]),
    .done(done_v[0]), .pass(pass_v[0]), .err_cnt(err0)
  );

  f5_checker #(.SETTLE(1), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a_v[1]), .b(b_v[1]),
    .x(x_v[1]), .y(y_v[1]), .vec_idx(vec_v[1]), .busy(busy_v[1]),
    .done(done_v[1]), .pass(pass_v[1]), .err_cnt(err1)
  );

  f5_checker #(.SETTLE(3), .CNT_W(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a_v[2]), .b(b_v[2]),
    .x(x_v[2]), .y(y_v[2]), .vec_idx(vec_v[2]), .busy(busy_v[2]),
    .done(done_v[2]), .pass(pass_v[2]), .err_cnt(err2)
  );

  function automatic int err_of(int s);
    case (s)
      0:       return int'(err0);
      1:       return int'(err1);
      default: return int'(err2);
    endcase
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  typedef struct {
    int lat;
    int err;
    int pas;
    int vec;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    int dut;
    int mode;
    int lat;
    int err;
    int pas;
    int vec;
    bit walk;
  } vec_t;

  vec_t tbl [9];

  task automatic pop_cmp(string tag, int lat, int s);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_latency"}, lat, e.lat);
      chk({tag, "_err_cnt"}, err_of(s), e.err);
      chk({tag, "_pass"}, int'(pass_v[s]), e.pas);
      chk({tag, "_vec_idx"}, int'(vec_v[s]), e.vec);
    end
  endtask

  // Launch a run and wait (bounded) for done; k counts cycles after edge T0.
  task automatic run(int s, int m, int lat, int err, int pas, int vec, bit walk);
    exp_t e;
    int   k;
    int   sp;
    int   ev;
    int   err_hold;
    bit   seen;
    sp = settle_of[s] + 1;
    mode_v[s] = m;
    e.lat = lat; e.err = err; e.pas = pas; e.vec = vec;
    sb.push_back(e);
    @(negedge clk); start_v[s] = 1'b1;
    @(negedge clk); start_v[s] = 1'b0;
    k = 1;
    seen = 1'b0;
    while (!seen && k < 64) begin
      if (walk) begin
        chk("walk_busy", int'(busy_v[s]), 1);
        if (k <= 4 * sp) begin
          ev = (k - 1) / sp;
          chk("walk_vec_idx", int'(vec_v[s]), ev);
          chk("walk_x", int'(x_v[s]), ev / 2);
          chk("walk_y", int'(y_v[s]), ev % 2);
        end
      end
      if (done_v[s]) begin
        seen = 1'b1;
      end else begin
        @(negedge clk);
        k++;
      end
    end
    if (!seen) begin
      chk("done_timeout", 0, 1);
      void'(sb.pop_front());
    end else begin
      pop_cmp("run", k, s);
      err_hold = err_of(s);
      @(negedge clk);
      chk("done_one_cycle", int'(done_v[s]), 0);
      chk("idle_busy", int'(busy_v[s]), 0);
      chk("err_hold", err_of(s), err_hold);
      chk("pass_hold", int'(pass_v[s]), pas);
    end
  endtask

  initial begin : main
    int k;
    int n;
    int first;
    int second;
    exp_t e;

    // {dut, mode, done latency, err_cnt, pass, vec_idx at done, walk check}
`ifdef F5_STOP_ON_FAIL_EN
    tbl[0] = '{0, 0,  9, 0, 1, 3, 1'b1};
    tbl[1] = '{0, 1,  5, 1, 0, 1, 1'b0};
    tbl[2] = '{0, 0,  9, 0, 1, 3, 1'b0};
    tbl[3] = '{0, 2,  3, 2, 0, 0, 1'b0};
    tbl[4] = '{1, 2,  3, 2, 0, 0, 1'b0};
    tbl[5] = '{1, 1,  5, 1, 0, 1, 1'b0};
    tbl[6] = '{1, 0,  9, 0, 1, 3, 1'b0};
    tbl[7] = '{2, 0, 17, 0, 1, 3, 1'b1};
    tbl[8] = '{2, 1,  9, 1, 0, 1, 1'b0};
`else
    tbl[0] = '{0, 0,  9, 0, 1, 3, 1'b1};
    tbl[1] = '{0, 1,  9, 3, 0, 3, 1'b0};
    tbl[2] = '{0, 0,  9, 0, 1, 3, 1'b0};
    tbl[3] = '{0, 2,  9, 8, 0, 3, 1'b0};
    tbl[4] = '{1, 2,  9, 3, 0, 3, 1'b0};
    tbl[5] = '{1, 1,  9, 3, 0, 3, 1'b0};
    tbl[6] = '{1, 0,  9, 0, 1, 3, 1'b0};
    tbl[7] = '{2, 0, 17, 0, 1, 3, 1'b1};
    tbl[8] = '{2, 1, 17, 3, 0, 3, 1'b0};
`endif

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      mode_v[i]  = 0;
    end
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_x", int'(x_v[i]), 0);
      chk("rst_y", int'(y_v[i]), 0);
      chk("rst_vec_idx", int'(vec_v[i]), 0);
      chk("rst_busy", int'(busy_v[i]), 0);
      chk("rst_done", int'(done_v[i]), 0);
      chk("rst_pass", int'(pass_v[i]), 0);
      chk("rst_err_cnt", err_of(i), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 9; t++) begin
      run(tbl[t].dut, tbl[t].mode, tbl[t].lat, tbl[t].err,
          tbl[t].pas, tbl[t].vec, tbl[t].walk);
    end

    // start re-pulsed mid-run must be ignored: one done, still at T0+9.
    mode_v[0] = 0;
    e.lat = 9; e.err = 0; e.pas = 1; e.vec = 3;
    sb.push_back(e);
    @(negedge clk); start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0;
    n = 0; first = 0;
    for (k = 1; k <= 14; k++) begin
      if (k == 3) start_v[0] = 1'b1;
      if (k == 4) start_v[0] = 1'b0;
      if (done_v[0]) begin
        n++;
        if (first == 0) begin
          first = k;
          pop_cmp("restart", k, 0);
        end
      end
      @(negedge clk);
    end
    chk("restart_done_count", n, 1);
    if (first == 0) void'(sb.pop_front());

    // start held high relaunches on return to IDLE: done at 9 and 19.
    @(negedge clk); start_v[0] = 1'b1;
    @(negedge clk);
    n = 0; first = 0; second = 0;
    for (k = 1; k <= 22; k++) begin
      if (k == 11) start_v[0] = 1'b0;
      if (done_v[0]) begin
        n++;
        if (first == 0) first = k;
        else if (second == 0) second = k;
      end
      @(negedge clk);
    end
    chk("held_start_done_count", n, 2);
    chk("held_start_first", first, 9);
    chk("held_start_second", second, 19);
    chk("held_start_pass", int'(pass_v[0]), 1);

    // Asynchronous reset at cycle T0+5 of a failing run clears everything.
    mode_v[0] = 1;
    @(negedge clk); start_v[0] = 1'b1;
    @(negedge clk); start_v[0] = 1'b0;
    for (k = 1; k < 5; k++) @(negedge clk);
    chk("pre_rst_err_cnt", err_of(0), 1);
    chk("pre_rst_busy", int'(busy_v[0]), 1);
    chk("pre_rst_pass", int'(pass_v[0]), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_x", int'(x_v[0]), 0);
    chk("async_rst_y", int'(y_v[0]), 0);
    chk("async_rst_err_cnt", err_of(0), 0);
    chk("async_rst_busy", int'(busy_v[0]), 0);
    chk("async_rst_pass", int'(pass_v[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(0, 0, 9, 0, 1, 3, 1'b0);

    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
